// File: rtl/register_file_pkg.sv
// rtl/register_file_pkg.sv - shared widths, types and constants for the register file
package register_file_pkg;

  localparam int WORD_WIDTH      = 32;
  localparam int REG_COUNT       = 32;
  localparam int REG_INDEX_WIDTH = 5;
  localparam int ROB_TAG_WIDTH   = 4;

  typedef logic [WORD_WIDTH-1:0]      word_t;
  typedef logic [REG_INDEX_WIDTH-1:0] reg_index_t;
  typedef logic [ROB_TAG_WIDTH-1:0]   rob_tag_t;

  localparam rob_tag_t   NULL_TAG       = '0;
  localparam word_t      ZERO_WORD      = '0;
  localparam reg_index_t ZERO_REG_INDEX = '0;

endpackage

// File: rtl/register_read_port.sv
// rtl/register_read_port.sv - one combinational source-operand read with commit forwarding
module register_read_port
  import register_file_pkg::*;
(
  input  reg_index_t index,
  input  rob_tag_t   tags   [REG_COUNT],
  input  word_t      values [REG_COUNT],
  input  logic       commit_valid,
  input  rob_tag_t   commit_tag,
  input  word_t      commit_data,
  input  reg_index_t commit_target,
  output rob_tag_t   q,
  output word_t      v
);

  always_comb begin
    q = NULL_TAG;
    v = ZERO_WORD;
    if (index != ZERO_REG_INDEX) begin
      // Forward only when the committing entry is still the register's owner.
      if (commit_valid && commit_target == index && tags[index] == commit_tag) begin
        q = NULL_TAG;
        v = commit_data;
      end else begin
        q = tags[index];
        v = values[index];
      end
    end
  end

endmodule

// File: rtl/register_file.sv
// rtl/register_file.sv - architectural register file with rename tags, fed by ROB commits
module register_file
  import register_file_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       rollback_in,
  input  logic       dec_issue_in,
  input  reg_index_t dec_rd_in,
  input  rob_tag_t   dec_tag_in,
  input  reg_index_t dec_rs1_in,
  input  reg_index_t dec_rs2_in,
  output rob_tag_t   dec_Qj_out,
  output rob_tag_t   dec_Qk_out,
  output word_t      dec_Vj_out,
  output word_t      dec_Vk_out,
  input  logic       commit_rf_signal_in,
  input  rob_tag_t   commit_tag_in,
  input  word_t      commit_data_in,
  input  reg_index_t commit_target_in,
  output logic [31:0] commit_count_out
);

  word_t       value_q [REG_COUNT];
  rob_tag_t    tag_q   [REG_COUNT];
  logic [31:0] count_q;

  logic commit_we;
  logic issue_we;

  assign commit_we = commit_rf_signal_in && (commit_target_in != ZERO_REG_INDEX);
  assign issue_we  = dec_issue_in && (dec_rd_in != ZERO_REG_INDEX) && !rollback_in;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        value_q[i] <= ZERO_WORD;
        tag_q[i]   <= NULL_TAG;
      end
      count_q <= '0;
    end else begin
      if (commit_we) begin
        value_q[commit_target_in] <= commit_data_in;
        count_q                   <= count_q + 32'd1;
      end
      if (rollback_in) begin
        for (int i = 0; i < REG_COUNT; i++) begin
          tag_q[i] <= NULL_TAG;
        end
      end else begin
        if (commit_we && tag_q[commit_target_in] == commit_tag_in) begin
          tag_q[commit_target_in] <= NULL_TAG;
        end
        // Later assignment lets a same-cycle rename override the commit clear.
        if (issue_we) begin
          tag_q[dec_rd_in] <= dec_tag_in;
        end
      end
    end
  end

  assign commit_count_out = count_q;

  register_read_port u_rs1 (
    .index         (dec_rs1_in),
    .tags          (tag_q),
    .values        (value_q),
    .commit_valid  (commit_rf_signal_in),
    .commit_tag    (commit_tag_in),
    .commit_data   (commit_data_in),
    .commit_target (commit_target_in),
    .q             (dec_Qj_out),
    .v             (dec_Vj_out)
  );

  register_read_port u_rs2 (
    .index         (dec_rs2_in),
    .tags          (tag_q),
    .values        (value_q),
    .commit_valid  (commit_rf_signal_in),
    .commit_tag    (commit_tag_in),
    .commit_data   (commit_data_in),
    .commit_target (commit_target_in),
    .q             (dec_Qk_out),
    .v             (dec_Vk_out)
  );

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - scoreboard bench for register_file with directed vectors
module tb_register_file;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rollback_in = 1'b0;
  logic        dec_issue_in = 1'b0;
  logic [4:0]  dec_rd_in = '0;
  logic [3:0]  dec_tag_in = '0;
  logic [4:0]  dec_rs1_in = '0;
  logic [4:0]  dec_rs2_in = '0;
  logic [3:0]  dec_Qj_out, dec_Qk_out;
  logic [31:0] dec_Vj_out, dec_Vk_out;
  logic        commit_rf_signal_in = 1'b0;
  logic [3:0]  commit_tag_in = '0;
  logic [31:0] commit_data_in = '0;
  logic [4:0]  commit_target_in = '0;
  logic [31:0] commit_count_out;

  register_file dut (
    .clk                 (clk),
    .rst                 (rst),
    .rollback_in         (rollback_in),
    .dec_issue_in        (dec_issue_in),
    .dec_rd_in           (dec_rd_in),
    .dec_tag_in          (dec_tag_in),
    .dec_rs1_in          (dec_rs1_in),
    .dec_rs2_in          (dec_rs2_in),
    .dec_Qj_out          (dec_Qj_out),
    .dec_Qk_out          (dec_Qk_out),
    .dec_Vj_out          (dec_Vj_out),
    .dec_Vk_out          (dec_Vk_out),
    .commit_rf_signal_in (commit_rf_signal_in),
    .commit_tag_in       (commit_tag_in),
    .commit_data_in      (commit_data_in),
    .commit_target_in    (commit_target_in),
    .commit_count_out    (commit_count_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  qj;
    logic [31:0] vj;
    logic [3:0]  qk;
    logic [31:0] vk;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk32(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
    end
  endtask

  // Monitor: outputs are combinational, so sample mid-cycle for the vector driven this cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk32(e.name, "Qj",    {28'd0, dec_Qj_out}, {28'd0, e.qj});
      chk32(e.name, "Vj",    dec_Vj_out,          e.vj);
      chk32(e.name, "Qk",    {28'd0, dec_Qk_out}, {28'd0, e.qk});
      chk32(e.name, "Vk",    dec_Vk_out,          e.vk);
      chk32(e.name, "count", commit_count_out,    e.cnt);
    end
  end

  task automatic step(
    input string nm, input logic r, input logic rb,
    input logic iss, input logic [4:0] rd, input logic [3:0] tg,
    input logic [4:0] rs1, input logic [4:0] rs2,
    input logic cv, input logic [3:0] ct, input logic [31:0] cd, input logic [4:0] tgt,
    input logic [3:0] eqj, input logic [31:0] evj,
    input logic [3:0] eqk, input logic [31:0] evk, input logic [31:0] ecnt);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; rollback_in = rb;
    dec_issue_in = iss; dec_rd_in = rd; dec_tag_in = tg;
    dec_rs1_in = rs1; dec_rs2_in = rs2;
    commit_rf_signal_in = cv; commit_tag_in = ct; commit_data_in = cd; commit_target_in = tgt;
    e.name = nm; e.qj = eqj; e.vj = evj; e.qk = eqk; e.vk = evk; e.cnt = ecnt;
    sb.push_back(e);
  endtask

  initial begin
    //    name          rst rb iss rd tg  rs1 rs2 cv ct cd            tgt   Qj Vj            Qk Vk     cnt
    step("reset",        0, 0, 0,  0, 0,  5,  0,  0, 0, 32'h0,        0,    0, 32'h0,        0, 32'h0, 0);
    step("issue3",       1, 0, 1,  3, 2,  3,  0,  0, 0, 32'h0,        0,    0, 32'h0,        0, 32'h0, 0);
    step("pend3",        1, 0, 0,  0, 0,  3,  0,  0, 0, 32'h0,        0,    2, 32'h0,        0, 32'h0, 0);
    step("fwd3",         1, 0, 0,  0, 0,  3,  3,  1, 2, 32'hDEADBEEF, 3,    0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0);
    step("after3",       1, 0, 0,  0, 0,  3,  3,  0, 0, 32'h0,        0,    0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 1);
    step("issue4a",      1, 0, 1,  4, 1,  4,  0,  0, 0, 32'h0,        0,    0, 32'h0,        0, 32'h0, 1);
    step("issue4b",      1, 0, 1,  4, 5,  4,  0,  0, 0, 32'h0,        0,    1, 32'h0,        0, 32'h0, 1);
    step("stale4",       1, 0, 0,  0, 0,  4,  4,  1, 1, 32'h11,       4,    5, 32'h0,        5, 32'h0, 1);
    step("after4",       1, 0, 0,  0, 0,  4,  0,  0, 0, 32'h0,        0,    5, 32'h11,       0, 32'h0, 2);
    step("race7",        1, 0, 1,  7, 9,  7,  0,  1, 6, 32'h22,       7,    0, 32'h0,        0, 32'h0, 2);
    step("after7",       1, 0, 0,  0, 0,  7,  0,  0, 0, 32'h0,        0,    9, 32'h22,       0, 32'h0, 3);
    step("issue1",       1, 0, 1,  1, 10, 0,  0,  0, 0, 32'h0,        0,    0, 32'h0,        0, 32'h0, 3);
    step("issue2",       1, 0, 1,  2, 11, 1,  0,  0, 0, 32'h0,        0,    10, 32'h0,       0, 32'h0, 3);
    step("rollback",     1, 1, 1,  8, 3,  1,  2,  0, 0, 32'h0,        0,    10, 32'h0,       11, 32'h0, 3);
    step("flushed_a",    1, 0, 0,  0, 0,  7,  2,  0, 0, 32'h0,        0,    0, 32'h22,       0, 32'h0, 3);
    step("flushed_b",    1, 0, 0,  0, 0,  8,  4,  0, 0, 32'h0,        0,    0, 32'h0,        0, 32'h11, 3);
    step("issue2b",      1, 0, 1,  2, 12, 0,  0,  0, 0, 32'h0,        0,    0, 32'h0,        0, 32'h0, 3);
    step("rb_commit",    1, 1, 0,  0, 0,  2,  0,  1, 12, 32'h33,      2,    0, 32'h33,       0, 32'h0, 3);
    step("after_rbc",    1, 0, 0,  0, 0,  2,  0,  0, 0, 32'h0,        0,    0, 32'h33,       0, 32'h0, 4);
    step("x0_write",     1, 0, 1,  0, 14, 0,  0,  1, 13, 32'hFFFFFFFF, 0,   0, 32'h0,        0, 32'h0, 4);
    step("x0_after",     1, 0, 0,  0, 0,  0,  0,  0, 0, 32'h0,        0,    0, 32'h0,        0, 32'h0, 4);
    step("issue3b",      1, 0, 1,  3, 7,  0,  0,  0, 0, 32'h0,        0,    0, 32'h0,        0, 32'h0, 4);
    step("pend3b",       1, 0, 0,  0, 0,  3,  0,  0, 0, 32'h0,        0,    7, 32'hDEADBEEF, 0, 32'h0, 4);
    step("async_rst",    0, 0, 0,  0, 0,  3,  7,  0, 0, 32'h0,        0,    0, 32'h0,        0, 32'h0, 0);
    step("post_rst",     1, 0, 0,  0, 0,  3,  7,  0, 0, 32'h0,        0,    0, 32'h0,        0, 32'h0, 0);

    begin
      int guard = 0;
      while (sb.size() > 0 && guard < 10) begin
        @(posedge clk);
        guard++;
      end
      if (sb.size() > 0) begin
        errors++;
        checks++;
        $display("FAIL drain: %0d vectors unchecked, expected 0", sb.size());
      end
    end
    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- Architectural register file with per-register rename tags; the consumer of the reorder buffer's in-order commit stream.
- Decoder issue marks rd as pending on a ROB tag.
- ROB commit (commit_rf_signal/tag/data/target) writes the value and clears the pending tag only if it still matches.
- Supplies decoder with rs1/rs2 tag+value (with same-cycle commit forwarding); flushes all tags on rollback while keeping committed values.

Parameters:
WORD_WIDTH, 32, data width
REG_COUNT, 32, architectural registers (index width 5)
ROB_TAG_WIDTH, 4, tag width; tag 0 = NULL_TAG (never allocated), valid tags 1..2^ROB_TAG_WIDTH-1

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
rollback_in  in  1  one-cycle flush pulse from ROB
dec_issue_in  in  1  decoder issues an instruction this cycle
dec_rd_in  in  5  destination; decoder drives 0 for non-writing instructions (store, branch)
dec_tag_in  in  ROB_TAG_WIDTH  ROB tag allocated to the issuing instruction
dec_rs1_in  in  5  source 1 index
dec_rs2_in  in  5  source 2 index
dec_Qj_out  out  ROB_TAG_WIDTH  pending tag of rs1, NULL_TAG if value valid
dec_Qk_out  out  ROB_TAG_WIDTH  pending tag of rs2
dec_Vj_out  out  WORD_WIDTH  value of rs1
dec_Vk_out  out  WORD_WIDTH  value of rs2
commit_rf_signal_in  in  1  ROB commit valid
commit_tag_in  in  ROB_TAG_WIDTH  tag of committing entry
commit_data_in  in  WORD_WIDTH  result
commit_target_in  in  5  destination register
commit_count_out  out  32  number of register-writing commits since reset

Behaviour:
- State: value[0..31], tag[0..31], commit counter.
- Reset (rst=0, asynchronous): all value=0, all tag=NULL_TAG, commit_count_out=0; read outputs therefore 0/NULL.
- x0: never written, never tagged; reads of index 0 always return Q=NULL_TAG, V=0.
- Commit (commit_rf_signal_in=1, target!=0), registered:
  - value[target] <= commit_data_in.
  - If tag[target]==commit_tag_in, tag[target] <= NULL_TAG; otherwise tag unchanged (a younger writer owns it).
  - commit_count_out increments by 1, wrapping at 2^32.
  - Target 0: no state change, no count.
- Issue (dec_issue_in=1, rd!=0, rollback_in=0): tag[rd] <= dec_tag_in. Issue wins over a same-cycle commit clear to the same register; the commit value is still written.
- Rollback (rollback_in=1):
  - All tags <= NULL_TAG; values retained.
  - Same-cycle issue ignored.
  - Same-cycle commit still writes value and counts; tag result is NULL regardless.
- Read (combinational, zero latency), per source s:
  - If s==0: Q=NULL, V=0.
  - Else if commit valid, commit_target_in==s, and tag[s]==commit_tag_in: Q=NULL, V=commit_data_in (forwarding).
  - Else: Q=tag[s], V=value[s].
  - Reads see pre-edge state; same-cycle issue does not affect them. The decoder handles rs==rd of its own instruction naturally, since the read precedes the rename.
- No handshake back-pressure; RF always accepts. ROB guarantees at most one commit per cycle and never commits a NULL tag.

Decomposition:
- Shared header gets:
  - WORD_RANGE, REG_INDEX_RANGE, ROB_TAG_RANGE
  - NULL_TAG, ZERO_WORD, ZERO_REG_INDEX
  - REG_COUNT
- Sub-module register_read_port, instantiated twice (rs1, rs2). Inputs: index, tag/value arrays, commit bus. Outputs: Q, V with the forwarding rule above.

Test Plan:
- Reset then read rs1=5, rs2=0 -> Q=0,V=0 both; commit_count_out=0; async reset mid-run (rst low between edges) clears tag[3]=7 immediately.
- Issue rd=3 tag=2; next cycle read rs1=3 -> Qj=2; commit tag=2 target=3 data=0xDEADBEEF -> same-cycle read Qj=0,Vj=0xDEADBEEF; after edge tag[3]=NULL, value[3]=0xDEADBEEF, count=1.
- Issue rd=4 tag=1, later issue rd=4 tag=5; commit tag=1 target=4 data=0x11 -> value[4]=0x11, Q stays 5, no forwarding on rs=4.
- Same cycle: commit tag=6 target=7 data=0x22 and issue rd=7 tag=9 -> value[7]=0x22, tag[7]=9.
- With tags pending on x1,x2, pulse rollback_in together with issue rd=8 tag=3 -> all tags NULL, tag[8] NULL, values unchanged.
- Commit target=0 data=0xFFFF_FFFF and issue rd=0 -> x0 reads 0/NULL, count unchanged.
